pipeline_stall_controller: RTL

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the hazard

---
 rtl/pipeline_stall_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
//============================================================================
//  Module      : pipeline_stall_controller
//  Description : Stall/flush sequencer for the 5-stage MIPS pipeline. It
//                combines the hazard stall request, the ID-stage branch
//                resolution and the MEM-stage SRAM handshake. It drives the
//                freeze/flush/bubble controls of the PC and stage registers
//                and owns the SRAM request FSM with its timeout watchdog.
//                Optional macro STALL_STATS_EN enables the saturating
//                stall-statistics counters.
//  Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16,  // max WAIT cycles before error (>= 2)
  parameter int CNT_W       = 5,   // 2**CNT_W must exceed MEM_TIMEOUT
  parameter int STAT_W      = 16   // statistics counter width
) (
  input  logic              clk,
  input  logic              rst,              // asynchronous, active low
  input  logic              hazard_detected,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              sram_ready,
  output logic              sram_start,
  output logic              pc_freeze,
  output logic              pc_sel_branch,
  output logic              if_id_freeze,
  output logic              if_id_flush,
  output logic              id_exe_freeze,
  output logic              id_exe_bubble,
  output logic              exe_mem_freeze,
  output logic              mem_wb_bubble,
  output logic              mem_error,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] hz_stall_cnt,
  output logic [STAT_W-1:0] mem_stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Last WAIT count value on which a missing sram_ready means timeout.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             mem_stall;
  logic             hz_stall;
  logic             br_flush;

  // Next-state logic plus the Mealy SRAM strobe and memory stall.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    sram_start = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req) begin
          sram_start = 1'b1;
          mem_stall  = 1'b1;
          next_state = ST_WAIT;
          next_cnt   = '0;
        end
      end
      ST_WAIT: begin
        // The pipeline advances in the very cycle the SRAM reports done.
        mem_stall = ~sram_ready;
        next_cnt  = wait_cnt + CNT_W'(1);
        if (sram_ready) begin
          next_state = ST_RUN;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          next_state = ST_ERR;
        end
      end
      ST_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        // Unreachable encoding: hold the pipeline and fall back to RUN.
        mem_stall  = 1'b1;
        next_state = ST_RUN;
      end
    endcase
  end

  // FSM state and WAIT counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // Priority: memory stall, then hazard, then branch. A hazard blocks the
  // branch because the branch compared stale operands.
  assign hz_stall = hazard_detected & ~mem_stall;
  assign br_flush = branch_taken & ~mem_stall & ~hazard_detected;

  assign pc_freeze      = mem_stall | hz_stall;
  assign if_id_freeze   = mem_stall | hz_stall;
  assign pc_sel_branch  = br_flush;
  assign if_id_flush    = br_flush;
  assign id_exe_freeze  = mem_stall;
  assign exe_mem_freeze = mem_stall;
  assign mem_wb_bubble  = mem_stall;
  assign id_exe_bubble  = hz_stall;
  assign mem_error      = (state == ST_ERR);

`ifdef STALL_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] hz_cnt_q;
  logic [STAT_W-1:0] mem_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;

  // Saturating stall statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hz_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (stats_clr) begin
      hz_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz_stall && (hz_cnt_q != STAT_MAX)) begin
        hz_cnt_q <= hz_cnt_q + STAT_W'(1);
      end
      if (mem_stall && (mem_cnt_q != STAT_MAX)) begin
        mem_cnt_q <= mem_cnt_q + STAT_W'(1);
      end
      if (br_flush && (flush_cnt_q != STAT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + STAT_W'(1);
      end
    end
  end

  assign hz_stall_cnt  = hz_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`else
  // Statistics disabled: ports stay, counters read zero, clear is ignored.
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign hz_stall_cnt     = '0;
  assign mem_stall_cnt    = '0;
  assign flush_cnt        = '0;
`endif

endmodule

`default_nettype wire
